// File: rtl/work_dispatch_ctrl_pkg.sv
// Shared definitions for the work dispatch controller: FSM state encoding,
// the sentinel nonce reported on a watchdog timeout, the default core
// start-up delay and the per-core nonce partition helper.
package work_dispatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WARMUP = 3'd2,
    ST_RUN    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  localparam logic [31:0] SENTINEL_NONCE         = 32'hFFFF_FFFF;
  localparam int          DEFAULT_STARTUP_CYCLES = 63;

  // Start offset of core idx when the 2^32 nonce space is split evenly over n cores.
  function automatic logic [31:0] core_offset(input int unsigned idx, input int unsigned n);
    logic [63:0] stride;
    logic [63:0] prod;
    stride = 64'h1_0000_0000 / 64'(n);
    prod   = stride * 64'(idx);
    return prod[31:0];
  endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous golden-nonce queue. Synchronous clear, push is ignored when
// full (unless a pop frees a slot in the same cycle), pop is ignored when
// empty. Head word is presented combinationally on data_o.
module nonce_fifo
  import work_dispatch_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);
  assign data_o    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; clear has priority over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/work_dispatch_ctrl.sv
// Work dispatch controller: partitions the nonce space over NUM_CORES hash
// cores, sequences their reset/warm-up, captures golden nonces, queues them
// round-robin into nonce_fifo and paces them out over the serial transmitter.
// Optional feature macro: WORK_TIMEOUT_EN (RUN watchdog that reports the
// sentinel nonce after TIMEOUT_CYCLES without every core hitting).
module work_dispatch_ctrl
  import work_dispatch_ctrl_pkg::*;
#(
  parameter int          NUM_CORES      = 2,
  parameter int          STARTUP_CYCLES = DEFAULT_STARTUP_CYCLES,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   new_work,
  input  logic [31:0]            work_nonce,
  input  logic [31:0]            work_target0,
  input  logic [31:0]            work_target1,
  output logic [NUM_CORES-1:0]   core_rst,
  output logic [32*NUM_CORES-1:0] core_nonce,
  output logic [31:0]            core_target0,
  output logic [31:0]            core_target1,
  input  logic [NUM_CORES-1:0]   core_ready,
  input  logic [32*NUM_CORES-1:0] core_nonce_out,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic [31:0]            tx_word,
  output logic                   active,
  output logic                   overflow
);

  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [NUM_CORES-1:0] ALL_CORES = {NUM_CORES{1'b1}};

  state_e                      state_q, state_d;
  logic [31:0]                 warm_cnt_q, warm_cnt_d;
  logic [PW-1:0]               arb_ptr_q, arb_ptr_d;
  logic [NUM_CORES-1:0]        hit_vld_q, hit_vld_d;
  logic [NUM_CORES-1:0][31:0]  hit_val_q, hit_val_d;
  logic [NUM_CORES-1:0]        core_rst_q, core_rst_d;
  logic [NUM_CORES-1:0][31:0]  core_nonce_q, core_nonce_d;
  logic [31:0]                 target0_q, target0_d;
  logic [31:0]                 target1_q, target1_d;
  logic [31:0]                 tx_word_q, tx_word_d;
  logic                        tx_send_q, tx_send_d;
  logic                        sent2_q, sent2_d;
  logic                        overflow_q, overflow_d;
  logic                        active_q, active_d;

  logic                        grant_vld_s;
  logic [PW-1:0]               grant_idx_s;
  logic [PW-1:0]               cand_s;
  logic                        arb_push_s;
  logic                        timeout_fire_s;
  logic                        send_s;
  logic                        fifo_clr_s, fifo_push_s, fifo_pop_s;
  logic                        fifo_full_s, fifo_empty_s;
  logic [31:0]                 fifo_wdata_s, fifo_rdata_s;

  nonce_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr_s),
    .push_i  (fifo_push_s),
    .data_i  (fifo_wdata_s),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

`ifdef WORK_TIMEOUT_EN
  logic [31:0] run_cnt_q, run_cnt_d;

  // Watchdog: counts RUN cycles and fires once the limit is reached with a core still searching.
  always_comb begin
    timeout_fire_s = 1'b0;
    run_cnt_d      = run_cnt_q;
    if (new_work) begin
      run_cnt_d = 32'd0;
    end else if (state_q == ST_RUN) begin
      if ((run_cnt_q == (TIMEOUT_CYCLES - 32'd1)) && !(&core_rst_q)) begin
        timeout_fire_s = 1'b1;
      end else begin
        timeout_fire_s = 1'b0;
      end
      run_cnt_d = run_cnt_q + 32'd1;
    end else begin
      run_cnt_d = 32'd0;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q <= 32'd0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end
`else
  localparam logic [31:0] timeout_unused = TIMEOUT_CYCLES;
  assign timeout_fire_s = 1'b0;
`endif

  // Round-robin search for the first occupied hit register starting at the pointer.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_s = arb_ptr_q + PW'(k);
      if (!grant_vld_s && hit_vld_q[cand_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s;
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Sequencing FSM, hit capture, hit-to-FIFO transfer and new-work latching.
  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    arb_ptr_d    = arb_ptr_q;
    hit_vld_d    = hit_vld_q;
    hit_val_d    = hit_val_q;
    core_rst_d   = core_rst_q;
    core_nonce_d = core_nonce_q;
    target0_d    = target0_q;
    target1_d    = target1_q;
    overflow_d   = overflow_q;
    fifo_clr_s   = 1'b0;
    fifo_push_s  = 1'b0;
    fifo_wdata_s = 32'd0;

    // One hit register per cycle moves into the queue; the sentinel push wins on timeout.
    arb_push_s = grant_vld_s && !fifo_full_s && !timeout_fire_s;
    if (arb_push_s) begin
      fifo_push_s            = 1'b1;
      fifo_wdata_s           = hit_val_q[grant_idx_s];
      hit_vld_d[grant_idx_s] = 1'b0;
      arb_ptr_d              = (NUM_CORES == 1) ? '0 : grant_idx_s + PW'(1);
    end else begin
      arb_ptr_d = arb_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        core_rst_d = ALL_CORES;
      end
      ST_LOAD: begin
        core_rst_d = '0;
        warm_cnt_d = 32'd0;
        state_d    = ST_WARMUP;
      end
      ST_WARMUP: begin
        // core_ready is untrustworthy while the cores come out of reset.
        if ((warm_cnt_q + 32'd1) >= 32'(STARTUP_CYCLES)) begin
          warm_cnt_d = 32'd0;
          state_d    = ST_RUN;
        end else begin
          warm_cnt_d = warm_cnt_q + 32'd1;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (core_ready[i]) begin
            // A register emptied by this cycle's grant can take the new hit.
            if (!hit_vld_q[i] || (arb_push_s && (grant_idx_s == PW'(i)))) begin
              hit_vld_d[i]  = 1'b1;
              hit_val_d[i]  = core_nonce_out[32*i +: 32];
              core_rst_d[i] = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            hit_vld_d[i] = hit_vld_d[i];
          end
        end
        if (timeout_fire_s) begin
          core_rst_d = ALL_CORES;
          state_d    = ST_DRAIN;
          if (!fifo_full_s) begin
            fifo_push_s  = 1'b1;
            fifo_wdata_s = SENTINEL_NONCE;
          end else begin
            fifo_push_s = 1'b0;
          end
        end else if (&core_rst_q) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!(|hit_vld_q) && fifo_empty_s && !tx_busy) begin
          state_d    = ST_IDLE;
          core_rst_d = ALL_CORES;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        core_rst_d = ALL_CORES;
      end
    endcase

    // New work overrides everything: old hits and queued nonces are discarded.
    if (new_work) begin
      state_d     = ST_LOAD;
      core_rst_d  = ALL_CORES;
      hit_vld_d   = '0;
      fifo_clr_s  = 1'b1;
      fifo_push_s = 1'b0;
      arb_ptr_d   = '0;
      warm_cnt_d  = 32'd0;
      target0_d   = work_target0;
      target1_d   = work_target1;
      for (int i = 0; i < NUM_CORES; i++) begin
        core_nonce_d[i] = work_nonce + core_offset(i, NUM_CORES);
      end
    end else begin
      fifo_clr_s = 1'b0;
    end
  end

  // Transmit pacing: at most one pulse every three cycles, never while busy or on new work.
  always_comb begin
    send_s     = !fifo_empty_s && !tx_busy && !tx_send_q && !sent2_q && !new_work;
    fifo_pop_s = send_s;
    tx_send_d  = send_s;
    sent2_d    = tx_send_q;
    if (send_s) begin
      tx_word_d = fifo_rdata_s;
    end else begin
      tx_word_d = tx_word_q;
    end
    active_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      warm_cnt_q   <= 32'd0;
      arb_ptr_q    <= '0;
      hit_vld_q    <= '0;
      hit_val_q    <= '0;
      core_rst_q   <= ALL_CORES;
      core_nonce_q <= '0;
      target0_q    <= 32'd0;
      target1_q    <= 32'd0;
      tx_word_q    <= 32'd0;
      tx_send_q    <= 1'b0;
      sent2_q      <= 1'b0;
      overflow_q   <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      arb_ptr_q    <= arb_ptr_d;
      hit_vld_q    <= hit_vld_d;
      hit_val_q    <= hit_val_d;
      core_rst_q   <= core_rst_d;
      core_nonce_q <= core_nonce_d;
      target0_q    <= target0_d;
      target1_q    <= target1_d;
      tx_word_q    <= tx_word_d;
      tx_send_q    <= tx_send_d;
      sent2_q      <= sent2_d;
      overflow_q   <= overflow_d;
      active_q     <= active_d;
    end
  end

  assign core_rst     = core_rst_q;
  assign core_nonce   = core_nonce_q;
  assign core_target0 = target0_q;
  assign core_target1 = target1_q;
  assign tx_send      = tx_send_q;
  assign tx_word      = tx_word_q;
  assign active       = active_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_work_dispatch_ctrl.sv
// Scoreboard bench for work_dispatch_ctrl (NUM_CORES=2, FIFO_DEPTH=4).
// Stimulus pushes expected tx words into exp_q; the negedge monitor pops and
// compares on every tx_send pulse, also checking pacing and tx_busy.
module tb_work_dispatch_ctrl;

  localparam int NC = 2;
`ifdef WORK_TIMEOUT_EN
  localparam logic [31:0] TMO = 32'd100;
`else
  localparam logic [31:0] TMO = 32'hFFFF_FFFF;
`endif

  logic        clk;
  logic        rst_n;
  logic        new_work;
  logic [31:0] work_nonce, work_target0, work_target1;
  logic [1:0]  core_rst, core_ready;
  logic [63:0] core_nonce, core_nonce_out;
  logic [31:0] core_target0, core_target1, tx_word;
  logic        tx_send, tx_busy, active, overflow;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulse_cnt = 0;
  int          last_pulse = -100;
  int          pc0;
  logic        busy_at_edge = 1'b0;
  logic [31:0] mon_exp;
  logic [31:0] exp_q [$];

  work_dispatch_ctrl #(
    .NUM_CORES(NC), .STARTUP_CYCLES(63), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .new_work(new_work), .work_nonce(work_nonce),
    .work_target0(work_target0), .work_target1(work_target1),
    .core_rst(core_rst), .core_nonce(core_nonce),
    .core_target0(core_target0), .core_target1(core_target1),
    .core_ready(core_ready), .core_nonce_out(core_nonce_out),
    .tx_send(tx_send), .tx_busy(tx_busy), .tx_word(tx_word),
    .active(active), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter and the tx_busy value seen by the DUT at each edge.
  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= tx_busy;
  end

  // Monitor: every tx_send pulse is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (tx_send) begin
      pulse_cnt++;
      chk("send_while_busy", {63'd0, busy_at_edge}, 64'd0);
      chk("pulse_spacing_ge3", {63'd0, ((cyc - last_pulse) >= 3)}, 64'd1);
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_send: tx_word 0x%08h, expected no pulse", tx_word);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("tx_word", {32'd0, tx_word}, {32'd0, mon_exp});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_new_work(input logic [31:0] n, input logic [31:0] t0, input logic [31:0] t1);
    work_nonce   = n;
    work_target0 = t0;
    work_target1 = t1;
    new_work     = 1'b1;
    step(1);
    new_work     = 1'b0;
  endtask

  // LOAD cycle: core 1 starts half-way round the 32-bit nonce space.
  task automatic check_load(input logic [31:0] n, input logic [31:0] t0, input logic [31:0] t1);
    logic [63:0] e;
    e = {n + 32'h8000_0000, n};
    chk("load_core_nonce", core_nonce, e);
    chk("load_core_rst", {62'd0, core_rst}, 64'd3);
    chk("load_targets", {core_target1, core_target0}, {t1, t0});
    chk("load_active", {63'd0, active}, 64'd1);
  endtask

  task automatic start_work(input logic [31:0] n, input logic [31:0] t0, input logic [31:0] t1);
    pulse_new_work(n, t0, t1);
    check_load(n, t0, t1);
    step(1);
    chk("warmup_core_rst", {62'd0, core_rst}, 64'd0);
    step(63);
  endtask

  task automatic hit(input logic [1:0] rdy, input logic [31:0] n0, input logic [31:0] n1);
    core_ready     = rdy;
    core_nonce_out = {n1, n0};
    step(1);
    core_ready     = 2'b00;
  endtask

  task automatic wait_queue(input int bound, input string tag);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      step(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", tag, exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    new_work       = 1'b0;
    work_nonce     = 32'd0;
    work_target0   = 32'd0;
    work_target1   = 32'd0;
    core_ready     = 2'b00;
    core_nonce_out = 64'd0;
    tx_busy        = 1'b0;
    #12;
    chk("rst_core_rst", {62'd0, core_rst}, 64'd3);
    chk("rst_tx_send", {63'd0, tx_send}, 64'd0);
    chk("rst_tx_word", {32'd0, tx_word}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_active", {63'd0, active}, 64'd0);
    #10;
    rst_n = 1'b1;
    step(2);

    // Nonce 0: LOAD split, ignored warm-up ready, single RUN hit on core 1.
    pulse_new_work(32'h0000_0000, 32'h1111_2222, 32'h3333_4444);
    check_load(32'h0000_0000, 32'h1111_2222, 32'h3333_4444);
    step(1);
    chk("warmup_core_rst", {62'd0, core_rst}, 64'd0);
    step(8);
    hit(2'b01, 32'hDEAD_BEEF, 32'd0);
    step(1);
    chk("warmup_ready_ignored", {62'd0, core_rst}, 64'd0);
    step(53);
    step(3);
    exp_q.push_back(32'h1234_5678);
    hit(2'b10, 32'd0, 32'h1234_5678);
    chk("hit_core_rst", {62'd0, core_rst}, 64'd2);
    wait_queue(20, "single_hit");
    chk("run_after_one_hit", {63'd0, active}, 64'd1);

    // Simultaneous hits drain core 0 first, then core 1, then IDLE.
    start_work(32'h1000_0000, 32'hAAAA_0000, 32'hBBBB_0000);
    exp_q.push_back(32'h0000_000A);
    exp_q.push_back(32'h0000_000B);
    hit(2'b11, 32'h0000_000A, 32'h0000_000B);
    chk("both_hit_core_rst", {62'd0, core_rst}, 64'd3);
    wait_queue(30, "dual_hit");
    step(3);
    chk("idle_after_drain", {63'd0, active}, 64'd0);
    chk("idle_core_rst", {62'd0, core_rst}, 64'd3);

    // tx_busy held: FIFO fills, hit registers absorb, repeat hit overflows.
    start_work(32'h2000_0000, 32'h0, 32'h0);
    tx_busy = 1'b1;
    pc0 = pulse_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'hA000_0001 + 32'(i));
      hit(2'b01, 32'hA000_0001 + 32'(i), 32'd0);
      step(2);
    end
    hit(2'b01, 32'hA000_0005, 32'd0);
    step(2);
    chk("overflow_before_repeat", {63'd0, overflow}, 64'd0);
    hit(2'b01, 32'hA000_0006, 32'd0);
    chk("overflow_on_repeat", {63'd0, overflow}, 64'd1);
    step(2);
    hit(2'b10, 32'd0, 32'hB000_0001);
    // Pointer sits past core 0 after the fourth push, so core 1 is served before core 0.
    exp_q.push_back(32'hB000_0001);
    exp_q.push_back(32'hA000_0005);
    step(175);
    chk("no_send_while_busy", 64'(pulse_cnt), 64'(pc0));
    tx_busy = 1'b0;
    wait_queue(60, "busy_release");
    step(3);
    chk("idle_after_busy_drain", {63'd0, active}, 64'd0);
    chk("overflow_sticky", {63'd0, overflow}, 64'd1);

    // New work with two queued nonces flushes them.
    start_work(32'h3000_0000, 32'h5, 32'h6);
    tx_busy = 1'b1;
    hit(2'b01, 32'hC000_0001, 32'd0);
    step(2);
    hit(2'b01, 32'hC000_0002, 32'd0);
    step(2);
    pc0 = pulse_cnt;
    pulse_new_work(32'h4000_0000, 32'h7, 32'h8);
    check_load(32'h4000_0000, 32'h7, 32'h8);
    tx_busy = 1'b0;
    step(30);
    chk("flush_no_old_pulse", 64'(pulse_cnt), 64'(pc0));
    step(34);

    // Asynchronous reset between pulses abandons the remaining queue.
    exp_q.push_back(32'hD000_0001);
    hit(2'b11, 32'hD000_0001, 32'hD000_0002);
    wait_queue(30, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_core_rst", {62'd0, core_rst}, 64'd3);
    chk("async_rst_tx_send", {63'd0, tx_send}, 64'd0);
    chk("async_rst_tx_word", {32'd0, tx_word}, 64'd0);
    chk("async_rst_active", {63'd0, active}, 64'd0);
    chk("async_rst_overflow", {63'd0, overflow}, 64'd0);
    pc0 = pulse_cnt;
    step(3);
    rst_n = 1'b1;
    step(20);
    chk("no_pulse_after_reset", 64'(pulse_cnt), 64'(pc0));

`ifdef WORK_TIMEOUT_EN
    // Watchdog with no hits reports the sentinel once, then IDLE.
    start_work(32'h5000_0000, 32'h1, 32'h2);
    exp_q.push_back(32'hFFFF_FFFF);
    wait_queue(200, "timeout");
    step(3);
    chk("idle_after_timeout", {63'd0, active}, 64'd0);
`endif

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
